// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: owns the fetch PC and splits each 16-byte fetch block into
// two or three dword-aligned icache requests tagged with IDs and a generation.
// Per-block metadata is posted to the predictor one cycle after acceptance.
// Backend flushes start a new generation; predicted redirects keep it.
module fetch_pc_gen #(
    parameter int                     VADDR_WIDTH  = 39,
    parameter logic [VADDR_WIDTH-1:0] RESET_VECTOR = VADDR_WIDTH'('h8000_0000)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       flush_valid,
    input  logic [VADDR_WIDTH-1:0]     flush_addr,
    input  logic                       pred_redirect_valid,
    input  logic [VADDR_WIDTH-1:0]     pred_redirect_addr,
    input  logic                       stall_in,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [2:0]                 req_lane_valid,
    output logic [3*VADDR_WIDTH-1:0]   req_vaddr,
    output logic [3*32-1:0]            req_id,
    output logic [31:0]                req_generation,
    output logic                       fetch_info_valid,
    output logic [VADDR_WIDTH-1:0]     fetch_vaddr,
    output logic [31:0]                fetch_id,
    output logic [31:0]                generation
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [VADDR_WIDTH-1:0] pc;
    logic [VADDR_WIDTH-1:0] pc_next;
    logic [31:0]            next_id;
    logic [31:0]            next_id_next;
    logic [31:0]            gen;
    logic [31:0]            gen_next;
    logic                   accept;

    // Next bundle contents, built from the post-edge pc / next_id
    logic                     valid_next;
    logic [2:0]               lane_valid_next;
    logic [VADDR_WIDTH-1:0]   lane0_addr;
    logic [VADDR_WIDTH-1:0]   lane1_addr;
    logic [VADDR_WIDTH-1:0]   lane2_addr;
    logic [3*VADDR_WIDTH-1:0] vaddr_next;
    logic [3*32-1:0]          id_next;

    // Redirect targets only ever carry word-aligned PCs; the low two bits
    // are deliberately discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{flush_addr[1:0], pred_redirect_addr[1:0]};

    // Next-state and PC/ID/generation update; flush outranks redirect, which
    // outranks stall, which outranks acceptance.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        next_id_next = next_id;
        gen_next     = gen;
        accept       = 1'b0;

        if (flush_valid) begin
            pc_next    = {flush_addr[VADDR_WIDTH-1:2], 2'b00};
            gen_next   = gen + 32'd1;
            state_next = RUN;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                RUN, HOLD: begin
                    if (pred_redirect_valid) begin
                        pc_next    = {pred_redirect_addr[VADDR_WIDTH-1:2], 2'b00};
                        state_next = RUN;
                    end else if (stall_in) begin
                        state_next = HOLD;
                    end else if (req_valid && req_ready) begin
                        accept       = 1'b1;
                        pc_next      = pc + VADDR_WIDTH'(16);
                        next_id_next = next_id + 32'd4;
                        state_next   = RUN;
                    end else begin
                        state_next = HOLD;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Bundle for the coming cycle: lane 2 is needed only when the block
    // starts in the upper word of a dword and so spills into a third dword.
    always_comb begin
        valid_next      = (state_next != IDLE) && !stall_in;
        lane0_addr      = {pc_next[VADDR_WIDTH-1:3], 3'b000};
        lane1_addr      = lane0_addr + VADDR_WIDTH'(8);
        lane2_addr      = lane0_addr + VADDR_WIDTH'(16);
        lane_valid_next = 3'b000;
        vaddr_next      = '0;
        id_next         = '0;
        if (valid_next) begin
            lane_valid_next = {pc_next[2], 2'b11};
            vaddr_next[0*VADDR_WIDTH +: VADDR_WIDTH] = lane0_addr;
            vaddr_next[1*VADDR_WIDTH +: VADDR_WIDTH] = lane1_addr;
            id_next[0*32 +: 32] = next_id_next;
            id_next[1*32 +: 32] = next_id_next + 32'd1;
            if (pc_next[2]) begin
                vaddr_next[2*VADDR_WIDTH +: VADDR_WIDTH] = lane2_addr;
                id_next[2*32 +: 32] = next_id_next + 32'd2;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Architectural fetch state: pc, next request ID and generation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= RESET_VECTOR;
            next_id <= 32'd0;
            gen     <= 32'd0;
        end else begin
            pc      <= pc_next;
            next_id <= next_id_next;
            gen     <= gen_next;
        end
    end

    // Registered request bundle; reset drops any presented bundle at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_valid      <= 1'b0;
            req_lane_valid <= 3'b000;
            req_vaddr      <= '0;
            req_id         <= '0;
        end else begin
            req_valid      <= valid_next;
            req_lane_valid <= lane_valid_next;
            req_vaddr      <= vaddr_next;
            req_id         <= id_next;
        end
    end

    // Block metadata: one-cycle pulse carrying the accepted block's start PC/ID
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_info_valid <= 1'b0;
            fetch_vaddr      <= '0;
            fetch_id         <= 32'd0;
        end else begin
            fetch_info_valid <= accept;
            if (accept) begin
                fetch_vaddr <= pc;
                fetch_id    <= next_id;
            end
        end
    end

    // The generation register is itself the registered tag for both consumers
    assign generation     = gen;
    assign req_generation = gen;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed scenarios followed by randomized
// traffic, with accepted bundles and block metadata checked by a scoreboard.
module tb_fetch_pc_gen;

    localparam int VA = 39;

    logic            clock;
    logic            reset;
    logic            start;
    logic            flush_valid;
    logic [VA-1:0]   flush_addr;
    logic            pred_redirect_valid;
    logic [VA-1:0]   pred_redirect_addr;
    logic            stall_in;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_lane_valid;
    logic [3*VA-1:0] req_vaddr;
    logic [95:0]     req_id;
    logic [31:0]     req_generation;
    logic            fetch_info_valid;
    logic [VA-1:0]   fetch_vaddr;
    logic [31:0]     fetch_id;
    logic [31:0]     generation;

    fetch_pc_gen #(.VADDR_WIDTH(VA), .RESET_VECTOR(39'h8000_0000)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .flush_valid        (flush_valid),
        .flush_addr         (flush_addr),
        .pred_redirect_valid(pred_redirect_valid),
        .pred_redirect_addr (pred_redirect_addr),
        .stall_in           (stall_in),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_lane_valid     (req_lane_valid),
        .req_vaddr          (req_vaddr),
        .req_id             (req_id),
        .req_generation     (req_generation),
        .fetch_info_valid   (fetch_info_valid),
        .fetch_vaddr        (fetch_vaddr),
        .fetch_id           (fetch_id),
        .generation         (generation)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state (spec-level: where fetch is, what is presented)
    logic          m_active = 1'b0;
    logic          m_valid  = 1'b0;
    logic [VA-1:0] m_pc     = 39'h8000_0000;
    logic [31:0]   m_id     = 32'd0;
    logic [31:0]   m_gen    = 32'd0;

    // Scoreboard queues
    logic [3*VA-1:0] q_vaddr[$];
    logic [95:0]     q_id[$];
    logic [2:0]      q_lv[$];
    logic [31:0]     q_gen[$];
    logic [VA-1:0]   q_fva[$];
    logic [31:0]     q_fid[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected lane addresses of the block starting at p
    function automatic logic [3*VA-1:0] exp_vaddr(input logic [VA-1:0] p);
        logic [VA-1:0] base;
        logic [VA-1:0] third;
        base  = p & ~39'd7;
        third = p[2] ? (base + 39'd16) : 39'd0;
        return {third, base + 39'd8, base};
    endfunction

    function automatic logic [95:0] exp_ids(input logic [VA-1:0] p, input logic [31:0] id);
        logic [31:0] third;
        third = p[2] ? (id + 32'd2) : 32'd0;
        return {third, id + 32'd1, id};
    endfunction

    function automatic logic [VA-1:0] rand_addr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if ($urandom_range(0, 7) == 0) r[38:6] = '1;
        return r[VA-1:0];
    endfunction

    // One clock of stimulus: inputs are already set; record the expected
    // acceptance, advance the model at the edge and check per-cycle outputs.
    task automatic tick();
        logic acc;
        acc = m_active && m_valid && req_ready && !stall_in && !flush_valid && !pred_redirect_valid;
        if (acc) begin
            q_vaddr.push_back(exp_vaddr(m_pc));
            q_id.push_back(exp_ids(m_pc, m_id));
            q_lv.push_back({m_pc[2], 2'b11});
            q_gen.push_back(m_gen);
            q_fva.push_back(m_pc);
            q_fid.push_back(m_id);
        end
        @(posedge clock);
        if (flush_valid) begin
            m_pc     = flush_addr & ~39'd3;
            m_gen    = m_gen + 32'd1;
            m_active = 1'b1;
        end else if (!m_active) begin
            if (start) m_active = 1'b1;
        end else if (pred_redirect_valid) begin
            m_pc = pred_redirect_addr & ~39'd3;
        end else if (acc) begin
            m_pc = m_pc + 39'd16;
            m_id = m_id + 32'd4;
        end
        m_valid = m_active && !stall_in;
        #1;
        chk("req_valid", req_valid, m_valid);
        chk("req_lane_valid", req_lane_valid, m_valid ? {m_pc[2], 2'b11} : 3'b000);
        chk("generation", generation, m_gen);
        chk("req_generation", req_generation, m_gen);
        chk("fetch_info_valid", fetch_info_valid, acc);
    endtask

    // Monitor: compare every bundle the DUT hands over and every metadata pulse
    always @(negedge clock) begin
        if (!reset && req_valid && req_ready && !stall_in && !flush_valid && !pred_redirect_valid) begin
            if (q_vaddr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_accept: got vaddr %0h expected no accept", req_vaddr);
            end else begin
                chk("sb_vaddr", req_vaddr, q_vaddr.pop_front());
                chk("sb_id", req_id, q_id.pop_front());
                chk("sb_lane_valid", req_lane_valid, q_lv.pop_front());
                chk("sb_gen", req_generation, q_gen.pop_front());
            end
        end
        if (!reset && fetch_info_valid) begin
            if (q_fva.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_info: got vaddr %0h expected no metadata", fetch_vaddr);
            end else begin
                chk("sb_fetch_vaddr", fetch_vaddr, q_fva.pop_front());
                chk("sb_fetch_id", fetch_id, q_fid.pop_front());
            end
        end
    end

    initial begin
        reset               = 1'b1;
        start               = 1'b0;
        flush_valid         = 1'b0;
        flush_addr          = '0;
        pred_redirect_valid = 1'b0;
        pred_redirect_addr  = '0;
        stall_in            = 1'b0;
        req_ready           = 1'b0;
        #2;
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_lane_valid", req_lane_valid, 3'b000);
        chk("rst_req_vaddr", req_vaddr, '0);
        chk("rst_req_id", req_id, '0);
        chk("rst_req_generation", req_generation, 32'd0);
        chk("rst_fetch_info_valid", fetch_info_valid, 1'b0);
        chk("rst_fetch_vaddr", fetch_vaddr, '0);
        chk("rst_fetch_id", fetch_id, 32'd0);
        chk("rst_generation", generation, 32'd0);
        #20;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Idle: nothing presented, redirect ignored
        pred_redirect_valid = 1'b1;
        pred_redirect_addr  = 39'h1234;
        req_ready           = 1'b1;
        tick();
        pred_redirect_valid = 1'b0;
        tick();

        // Start, then two back-to-back accepted blocks
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b1_vaddr", req_vaddr, {39'd0, 39'h8000_0008, 39'h8000_0000});
        chk("b1_id", req_id, {32'd0, 32'd1, 32'd0});
        tick();
        chk("b2_vaddr", req_vaddr, {39'd0, 39'h8000_0018, 39'h8000_0010});
        chk("b1_info_vaddr", fetch_vaddr, 39'h8000_0000);
        tick();

        // Flush to an unaligned target in the upper word of a dword
        flush_valid = 1'b1;
        flush_addr  = 39'h8000_0106;
        tick();
        flush_valid = 1'b0;
        chk("flush_vaddr", req_vaddr, {39'h8000_0110, 39'h8000_0108, 39'h8000_0100});
        chk("flush_id", req_id, {32'd10, 32'd9, 32'd8});
        chk("flush_gen", generation, 32'd1);
        tick();
        chk("flush_info_vaddr", fetch_vaddr, 39'h8000_0104);
        chk("after_flush_lane0", req_vaddr[VA-1:0], 39'h8000_0110);

        // Backpressure from the icache for three cycles
        req_ready = 1'b0;
        repeat (3) tick();
        req_ready = 1'b1;
        tick();

        // IFQ full for two cycles
        stall_in = 1'b1;
        repeat (2) tick();
        stall_in = 1'b0;
        tick();
        tick();

        // Flush and redirect together: flush target and new generation win
        flush_valid         = 1'b1;
        flush_addr          = 39'h4000_0020;
        pred_redirect_valid = 1'b1;
        pred_redirect_addr  = 39'h5000_0000;
        tick();
        flush_valid         = 1'b0;
        pred_redirect_valid = 1'b0;
        chk("flush_wins_lane0", req_vaddr[VA-1:0], 39'h4000_0020);

        // Predicted redirect keeps the generation
        pred_redirect_valid = 1'b1;
        pred_redirect_addr  = 39'h6000_004B;
        tick();
        pred_redirect_valid = 1'b0;
        tick();

        // PC wrap at the top of the address space
        flush_valid = 1'b1;
        flush_addr  = 39'h7F_FFFF_FFFC;
        tick();
        flush_valid = 1'b0;
        chk("wrap_vaddr", req_vaddr, {39'd8, 39'd0, 39'h7F_FFFF_FFF8});
        chk("wrap_lane_valid", req_lane_valid, 3'b111);
        tick();
        chk("wrap_next_lane0", req_vaddr[VA-1:0], 39'h8);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            flush_valid         = ($urandom_range(0, 19) == 0);
            flush_addr          = rand_addr();
            pred_redirect_valid = ($urandom_range(0, 14) == 0);
            pred_redirect_addr  = rand_addr();
            stall_in            = ($urandom_range(0, 4) == 0);
            req_ready           = ($urandom_range(0, 9) < 7);
            start               = ($urandom_range(0, 9) == 0);
            tick();
        end

        // Drain
        flush_valid         = 1'b0;
        pred_redirect_valid = 1'b0;
        stall_in            = 1'b0;
        req_ready           = 1'b0;
        start               = 1'b0;
        repeat (3) tick();
        chk("bundle_queue_empty", q_vaddr.size(), 0);
        chk("info_queue_empty", q_fva.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
